reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Issue-side hazard scoreboard for the 5-stage MIPS pipeline; it pairs with the bypass selector. The bypass selector only chooses where an operand comes from. This block records, per architectural register, how many more cycles a freshly issued producer needs before its result can be bypassed. From that it raises a stall for any consumer in ID that would read a value not yet available. It covers load-use hazards and multi-cycle (mul/div) producers. It sits in ID, beside the register file, and drives the IF/ID hold and ID/EXE bubble.

## Interface
Parameters:
- `AW`, 5, register-address width; register count is 2^AW.
- `CW`, 2, countdown width; maximum producer latency is 2^CW-1.

Ports:
- `clk` in 1: the only clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: the instruction in ID is valid.
- `id_rs` in AW: first source register.
- `id_rt` in AW: second source register.
- `id_rs_used` in 1: the instruction reads rs.
- `id_rt_used` in 1: the instruction reads rt.
- `id_RFWr` in 1: the instruction writes the register file.
- `id_dst` in AW: destination register.
- `id_lat` in CW: extra cycles before the result can be bypassed (ALU 0, load 1, mul/div up to 3).
- `flush` in 1: kill the instruction in ID this cycle.
- `stall` out 1: hold PC and IF/ID, inject a bubble into ID/EXE.
- `issue` out 1: the ID instruction advances this cycle.
- `busy_mask` out 2^AW: bit r is 1 while cnt[r] != 0.
- `stall_cycles` out 32: count of stalled cycles, saturating.

## Operation
- State: one CW-bit countdown `cnt[r]` per register, plus the `stall_cycles` register. `cnt[0]` is hard-wired to 0.
- Hazard terms, all combinational from registered state:
  - RAW_rs = id_rs_used & (id_rs != 0) & (cnt[id_rs] != 0).
  - RAW_rt is the same with rt.
  - WAW = id_RFWr & (id_dst != 0) & (cnt[id_dst] != 0).
- `stall` = id_valid & ~flush & (RAW_rs | RAW_rt | WAW).
- `issue` = id_valid & ~flush & ~stall.
- Per-cycle update, for every register r:
  - If `issue` & id_RFWr & id_dst==r & r!=0, then cnt[r] <= id_lat. Issue has priority over the decrement.
  - Else if cnt[r] != 0, then cnt[r] <= cnt[r]-1.
  - Else cnt[r] holds.
- An issue with id_lat=0 leaves cnt at 0. The result is bypassable from EXE in the next cycle, so no stall is generated.
- Dependent spacing: a consumer whose source has counter value k at its first ID cycle stalls exactly k cycles.
- WAW stall forces in-order completion. The bypass selector therefore always sees the youngest producer.
- `stall_cycles` increments on each cycle where `stall`=1, and saturates at 0xFFFFFFFF without wrapping.
- `flush` only suppresses `issue` and `stall`. Producers already in flight keep counting down; their results still retire.
- Writes to register 0 are never tracked. Sources equal to 0 never stall.

## Timing
- Reset (rst_n low, asynchronous): all cnt = 0, `busy_mask` = 0, `stall_cycles` = 0. Hence `stall` = 0, and `issue` = id_valid & ~flush.
- Release of reset is synchronous to `clk`. The first update happens on the first rising edge with rst_n high.
- `stall`/`issue` are combinational, valid the same cycle as the ID inputs, with no registered latency.
- `busy_mask` reflects cnt after the edge (registered). It has 1-cycle latency from `issue`.
- Load issued at edge N (id_lat=1), with a dependent in ID during cycle N+1:
  - stall=1 in cycle N+1.
  - cnt reaches 0 at edge N+2, and issue=1 in cycle N+2.
- Self-dependence (rs == dst of the same instruction) uses the pre-update cnt only. An instruction never stalls on itself.
- Reset asserted mid-countdown clears all state immediately, without waiting for a clock edge.

## Test plan
- Reset: hold rst_n=0 with id_valid=1 and random ID inputs.
  - Required: stall=0, busy_mask=0, stall_cycles=0.
  - Release reset, issue add $3 (lat 0), then in the next cycle an instruction reading $3: stall=0 throughout.
- Load-use: issue lw $5 (lat 1), then the next instruction reads rt=$5 with rt_used=1.
  - Required: exactly 1 stall cycle, then issue=1, and stall_cycles=1.
- Multi-cycle: issue mul $8 (lat 3), then a consumer reads rs=$8.
  - Required: 3 stall cycles; busy_mask[8] high for 3 cycles after the issue edge.
- WAW and $0:
  - Issue mul $9 (lat 3), then lw $9: 3 stall cycles.
  - Issue lw $0 (lat 1), then a consumer reads $0: stall=0, busy_mask=0.
- Flush and mid-operation reset:
  - Assert flush while a consumer would stall: stall=0, issue=0, and the countdown continues.
  - Pull rst_n low while cnt[8]=2: busy_mask=0 at once, with no clock edge needed.
- Saturation: preload stall_cycles near 0xFFFFFFFF (force), then hold a stall for 5 cycles.
  - Required: the count reads 0xFFFFFFFF and does not wrap.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Issue-side hazard scoreboard: per-register producer countdowns drive the
// ID stall/issue decision for load-use, multi-cycle and WAW hazards.
module reg_scoreboard #(
   parameter int unsigned AW = 5,
   parameter int unsigned CW = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [AW-1:0]         id_rs,
   input  logic [AW-1:0]         id_rt,
   input  logic                  id_rs_used,
   input  logic                  id_rt_used,
   input  logic                  id_RFWr,
   input  logic [AW-1:0]         id_dst,
   input  logic [CW-1:0]         id_lat,
   input  logic                  flush,
   output logic                  stall,
   output logic                  issue,
   output logic [(1<<AW)-1:0]    busy_mask,
   output logic [31:0]           stall_cycles
);

   localparam int unsigned NREG = 1 << AW;
   localparam int unsigned SCW  = 32;

   logic [CW-1:0]   cnt_q [NREG];
   logic [CW-1:0]   cnt_d [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [SCW-1:0]  stall_cycles_q;
   logic [SCW-1:0]  stall_cycles_d;

   logic raw_rs;
   logic raw_rt;
   logic waw;

   // Hazards look only at pre-update counters, so an instruction never waits on itself.
   always_comb begin
      raw_rs = id_rs_used && (id_rs != '0) && (cnt_q[id_rs] != '0);
      raw_rt = id_rt_used && (id_rt != '0) && (cnt_q[id_rt] != '0);
      waw    = id_RFWr    && (id_dst != '0) && (cnt_q[id_dst] != '0);
      stall  = id_valid && !flush && (raw_rs || raw_rt || waw);
      issue  = id_valid && !flush && !stall;
   end

   // Countdown update: a new producer reloads its destination, otherwise drain to zero.
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (issue && id_RFWr && (id_dst == AW'(r))) begin
            cnt_d[r] = id_lat;
         end else if (cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - CW'(1);
         end
         busy_d[r] = (cnt_d[r] != '0);
      end
   end

   // Saturating stall counter.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + SCW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
         busy_q         <= '0;
         stall_cycles_q <= '0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         busy_q         <= busy_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign busy_mask    = busy_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios plus random traffic,
// checked every cycle against a ready-time model of each register.
module tb_reg_scoreboard;

   localparam int unsigned AW   = 5;
   localparam int unsigned CW   = 2;
   localparam int unsigned NREG = 1 << AW;

   logic            clk;
   logic            rst_n;
   logic            id_valid;
   logic [AW-1:0]   id_rs;
   logic [AW-1:0]   id_rt;
   logic            id_rs_used;
   logic            id_rt_used;
   logic            id_RFWr;
   logic [AW-1:0]   id_dst;
   logic [CW-1:0]   id_lat;
   logic            flush;
   logic            stall;
   logic            issue;
   logic [NREG-1:0] busy_mask;
   logic [31:0]     stall_cycles;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Model: a register's result is bypassable from cycle ready[r] on.
   longint      cyc = 0;
   longint      ready [NREG];
   logic [31:0] m_scnt;

   reg_scoreboard #(.AW(AW), .CW(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rs_used   (id_rs_used),
      .id_rt_used   (id_rt_used),
      .id_RFWr      (id_RFWr),
      .id_dst       (id_dst),
      .id_lat       (id_lat),
      .flush        (flush),
      .stall        (stall),
      .issue        (issue),
      .busy_mask    (busy_mask),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic m_busy(input logic [AW-1:0] r);
      return (r != '0) && (cyc < ready[r]);
   endfunction

   function automatic logic [NREG-1:0] m_mask();
      logic [NREG-1:0] m;
      for (int i = 0; i < NREG; i++) m[i] = m_busy(AW'(i));
      return m;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NREG; i++) ready[i] = 0;
      m_scnt = 32'd0;
   endtask

   task automatic drive(input logic v, input int rs, input int rt, input logic ru,
                        input logic tu, input logic wr, input int dst, input int lat,
                        input logic fl);
      id_valid   = v;
      id_rs      = AW'(rs);
      id_rt      = AW'(rt);
      id_rs_used = ru;
      id_rt_used = tu;
      id_RFWr    = wr;
      id_dst     = AW'(dst);
      id_lat     = CW'(lat);
      flush      = fl;
   endtask

   task automatic idle();
      drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   // Called just after a falling edge with inputs applied; checks, clocks, returns at next falling edge.
   task automatic step();
      logic haz, es, ei;
      #1;
      haz = (id_rs_used && m_busy(id_rs)) || (id_rt_used && m_busy(id_rt)) ||
            (id_RFWr && m_busy(id_dst));
      es  = id_valid && !flush && haz;
      ei  = id_valid && !flush && !es;
      chk("stall", 64'(stall), 64'(es));
      chk("issue", 64'(issue), 64'(ei));
      chk("busy_mask", 64'(busy_mask), 64'(m_mask()));
      chk("stall_cycles", 64'(stall_cycles), 64'(m_scnt));
      @(posedge clk);
      if (rst_n) begin
         if (es && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
         if (ei && id_RFWr && id_dst != '0) ready[id_dst] = cyc + 1 + longint'(id_lat);
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      m_reset();
      rst_n = 1'b0;
      idle();
      @(negedge clk);

      // Reset held with random valid traffic.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom_range(0, 31), $urandom_range(0, 31), 1'b1, 1'b1, 1'b1,
               $urandom_range(0, 31), $urandom_range(0, 3), 1'b0);
         #1;
         chk("rst_stall", 64'(stall), 64'd0);
         chk("rst_issue", 64'(issue), 64'd1);
         chk("rst_busy", 64'(busy_mask), 64'd0);
         chk("rst_scnt", 64'(stall_cycles), 64'd0);
         step();
      end
      rst_n = 1'b1;

      // ALU producer then consumer: no stall.
      drive(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 3, 0, 1'b0); step();
      drive(1'b1, 3, 3, 1'b1, 1'b1, 1'b1, 4, 0, 1'b0); step();

      // Load-use on rt.
      drive(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 5, 1, 1'b0); step();
      drive(1'b1, 6, 5, 1'b0, 1'b1, 1'b1, 7, 0, 1'b0);
      #1 chk("lu_stall", 64'(stall), 64'd1);
      step(); step();
      chk("lu_scnt", 64'(stall_cycles), 64'd1);

      // Multi-cycle producer then rs consumer.
      drive(1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 8, 3, 1'b0); step();
      drive(1'b1, 8, 0, 1'b1, 1'b0, 1'b1, 10, 0, 1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("mul_scnt", 64'(stall_cycles), 64'd4);

      // WAW on $9.
      drive(1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 9, 3, 1'b0); step();
      drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9, 1, 1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("waw_scnt", 64'(stall_cycles), 64'd7);

      // $0 is never tracked.
      drive(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 0, 1, 1'b0); step();
      drive(1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0); step();
      idle(); step();
      chk("r0_busy", 64'(busy_mask), 64'd0);

      // Flush suppresses stall and issue; countdown continues.
      drive(1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 8, 3, 1'b0); step();
      drive(1'b1, 8, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
      #1 chk("fl_stall", 64'(stall), 64'd0);
      chk("fl_issue", 64'(issue), 64'd0);
      step();
      drive(1'b1, 8, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      idle(); step();

      // Asynchronous reset mid-countdown.
      drive(1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 8, 3, 1'b0); step();
      idle(); step();
      chk("mr_pre_busy", 64'(busy_mask[8]), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_busy", 64'(busy_mask), 64'd0);
      chk("mr_scnt", 64'(stall_cycles), 64'd0);
      m_reset();
      step();
      rst_n = 1'b1;

      // Saturation of the stall counter.
      force dut.stall_cycles_q = 32'hFFFF_FFFD;
      #1 release dut.stall_cycles_q;
      m_scnt = 32'hFFFF_FFFD;
      drive(1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 12, 3, 1'b0); step();
      drive(1'b1, 12, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      drive(1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 13, 3, 1'b0); step();
      drive(1'b1, 0, 13, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      chk("sat", 64'(stall_cycles), 64'hFFFF_FFFF);

      // Random traffic over a small register window to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7),
               $urandom_range(0, 3), $urandom_range(0, 9) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
